// File: rtl/data_ram_pkg.sv
// Shared definitions for the data RAM arbiter: access size codes, sequencer states
// and the size-to-byte-count helper.
package data_ram_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  function automatic logic [3:0] size_nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/data_ram_lane.sv
// Byte-lane datapath: merges store data into an old doubleword and sign/zero-extends
// load data, both driven by the access size.
module data_ram_lane
  import data_ram_pkg::*;
(
  input  logic [63:0] old_i,
  input  logic [63:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] merged_o,
  output logic [63:0] load_o
);

  logic [3:0] nbytes;
  logic       sign_bit;
  logic [7:0] fill;

  assign nbytes = size_nbytes(size_i);

  always_comb begin
    sign_bit = rdata_i[63];
    case (size_i)
      SZ_B:    sign_bit = rdata_i[7];
      SZ_H:    sign_bit = rdata_i[15];
      SZ_W:    sign_bit = rdata_i[31];
      default: sign_bit = rdata_i[63];
    endcase
  end

  assign fill = {8{sign_bit & ~unsigned_i}};

  // Bytes below nbytes come from the access; bytes above keep old data (store)
  // or take the extension fill (load).
  for (genvar gi = 0; gi < 8; gi++) begin : g_byte
    logic in_access;
    assign in_access            = (4'(gi) < nbytes);
    assign merged_o[gi*8 +: 8]  = in_access ? wdata_i[gi*8 +: 8] : old_i[gi*8 +: 8];
    assign load_o[gi*8 +: 8]    = in_access ? rdata_i[gi*8 +: 8] : fill;
  end

endmodule

// File: rtl/data_ram_arb.sv
// Two-port arbiter and access sequencer for the single-port 64-bit data RAM:
// sized loads with extension, read-modify-write for sub-doubleword stores, bounds check.
module data_ram_arb
  import data_ram_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [2*ADDR_W-1:0]   req_addr_i,
  input  logic [127:0]          req_wdata_i,
  input  logic [1:0]            req_we_i,
  input  logic [3:0]            req_size_i,
  input  logic [1:0]            req_unsigned_i,
  output logic [1:0]            rsp_valid_o,
  output logic [63:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [63:0]           mem_wdata_o,
  output logic                  mem_wen_o,
  input  logic [63:0]           mem_rdata_i
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic                uns_q, uns_d;
  logic                err_q, err_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [63:0]         data_q, data_d;

  logic [ADDR_W-1:0]   addr_p  [2];
  logic [63:0]         wdata_p [2];
  logic [1:0]          size_p  [2];

  logic                grant;
  logic                range_err;
  logic [63:0]         merged;
  logic [63:0]         load_ext;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign addr_p[gi]  = req_addr_i[gi*ADDR_W +: ADDR_W];
    assign wdata_p[gi] = req_wdata_i[gi*64 +: 64];
    assign size_p[gi]  = req_size_i[gi*2 +: 2];
  end

  assign grant = (&req_valid_i) ? prio_q : req_valid_i[1];

  // One extra bit so addresses near the top of the space cannot wrap past the check.
  assign range_err = ({1'b0, addr_q} + (ADDR_W+1)'(size_nbytes(size_q))) > MEM_LIMIT;

  data_ram_lane u_lane (
    .old_i      (data_q),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .rdata_i    (data_q),
    .merged_o   (merged),
    .load_o     (load_ext)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    we_d        = we_q;
    uns_d       = uns_q;
    err_d       = err_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wen_o   = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is gated by reset so nothing is offered while the sequencer is held.
        if ((|req_valid_i) && rst_n_i) begin
          req_ready_o[grant] = 1'b1;
          owner_d = grant;
          addr_d  = addr_p[grant];
          wdata_d = wdata_p[grant];
          size_d  = size_p[grant];
          we_d    = req_we_i[grant];
          uns_d   = req_unsigned_i[grant];
          err_d   = 1'b0;
          prio_d  = ~grant;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr_o = addr_q;
        if (range_err) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (!we_q) begin
          data_d  = mem_rdata_i;
          state_d = RESP;
        end else if (size_q == SZ_D) begin
          mem_wen_o   = 1'b1;
          mem_wdata_o = wdata_q;
          state_d     = RESP;
        end else begin
          data_d  = mem_rdata_i;
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_addr_o  = addr_q;
        mem_wen_o   = 1'b1;
        mem_wdata_o = merged;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        rsp_err_o            = err_q;
        rsp_rdata_o          = (we_q || err_q) ? 64'd0 : load_ext;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_data_ram_arb.sv
// Randomized bench for data_ram_arb: a byte-array RAM model plus a byte-level
// reference memory that predicts every response, latency and write count.
module tb_data_ram_arb;

  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 64;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          req_valid = '0;
  logic [1:0]          req_ready;
  logic [2*ADDR_W-1:0] req_addr = '0;
  logic [127:0]        req_wdata = '0;
  logic [1:0]          req_we = '0;
  logic [3:0]          req_size = '0;
  logic [1:0]          req_uns = '0;
  logic [1:0]          rsp_valid;
  logic [63:0]         rsp_rdata;
  logic                rsp_err;
  logic [ADDR_W-1:0]   mem_addr;
  logic [63:0]         mem_wdata;
  logic                mem_wen;
  logic [63:0]         mem_rdata;

  logic [7:0] ram     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  int n_checks = 0;
  int n_errors = 0;
  int wen_cnt = 0;
  int prio_model = 0;

  always #5 clk = ~clk;

  data_ram_arb #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_wen_o      (mem_wen),
    .mem_rdata_i    (mem_rdata)
  );

  // RAM: combinational read, 8-byte write; bytes past the end read as 0 and drop writes.
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++)
      if (mem_addr + 64'(i) < 64'(MEM_BYTES)) mem_rdata[i*8 +: 8] = ram[mem_addr + 64'(i)];
  end

  always @(posedge clk)
    if (mem_wen)
      for (int i = 0; i < 8; i++)
        if (mem_addr + 64'(i) < 64'(MEM_BYTES)) ram[mem_addr + 64'(i)] <= mem_wdata[i*8 +: 8];

  always @(negedge clk) if (mem_wen) wen_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [63:0] addr, input logic we,
                         input logic [1:0] sz, input logic uns, input logic [63:0] wd);
    req_addr[p*ADDR_W +: ADDR_W] = addr;
    req_wdata[p*64 +: 64]        = wd;
    req_we[p]                    = we;
    req_size[p*2 +: 2]           = sz;
    req_uns[p]                   = uns;
  endtask

  // Called just after the handshake edge; predicts and checks the whole transaction.
  task automatic finish_txn(input int p, input logic [63:0] addr, input logic we,
                            input logic [1:0] sz, input logic uns, input logic [63:0] wd);
    int nb, lat, w0;
    logic err_e;
    logic [63:0] v;
    nb    = 1 << sz;
    err_e = ({1'b0, addr} + 65'(nb)) > 65'(MEM_BYTES);
    v     = '0;
    if (!err_e && !we) begin
      for (int i = 0; i < nb; i++) v[i*8 +: 8] = ref_mem[addr + 64'(i)];
      if (!uns && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
    end
    w0 = wen_cnt;
    req_valid[p] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid == 2'b00 && lat < 10);
    chk("latency", 64'(lat), (we && !err_e && sz != 2'd3) ? 64'd3 : 64'd2);
    chk("rsp_owner", 64'(rsp_valid), 64'(2'b01 << p));
    chk("rsp_rdata", rsp_rdata, v);
    chk("rsp_err", 64'(rsp_err), 64'(err_e));
    chk("wen_cycles", 64'(wen_cnt - w0), (we && !err_e) ? 64'd1 : 64'd0);
    @(negedge clk);
    chk("rsp_pulse", 64'(rsp_valid), 64'd0);
    if (we && !err_e)
      for (int i = 0; i < nb; i++) ref_mem[addr + 64'(i)] = wd[i*8 +: 8];
    prio_model = 1 - p;
    $display("txn port=%0d addr=%h we=%0d sz=%0d uns=%0d lat=%0d err=%0b rdata=%h",
             p, addr, we, sz, uns, lat, rsp_err, rsp_rdata);
  endtask

  // Single-port transaction, entered at a negedge with the arbiter idle.
  task automatic do_txn(input int p, input logic [63:0] addr, input logic we,
                        input logic [1:0] sz, input logic uns, input logic [63:0] wd);
    int t;
    set_req(p, addr, we, sz, uns, wd);
    req_valid[p] = 1'b1;
    #1;
    t = 0;
    while (!req_ready[p] && t < 10) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("ready", 64'(req_ready), 64'(2'b01 << p));
    @(posedge clk);
    #1;
    finish_txn(p, addr, we, sz, uns, wd);
  endtask

  initial begin
    int g, t;
    for (int i = 0; i < MEM_BYTES; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end

    #2;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    req_valid = 2'b01;
    #1;
    chk("rst_ready_held", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(0, 64'h10, 1'b1, 2'd3, 1'b0, 64'h1122334455667788);
    do_txn(0, 64'h10, 1'b0, 2'd2, 1'b0, 64'd0);
    do_txn(0, 64'h13, 1'b1, 2'd0, 1'b0, 64'h00000000000000FF);
    do_txn(0, 64'h10, 1'b0, 2'd3, 1'b0, 64'd0);
    do_txn(0, 64'h13, 1'b0, 2'd0, 1'b0, 64'd0);
    do_txn(0, 64'h13, 1'b0, 2'd0, 1'b1, 64'd0);

    do_txn(0, 64'd1020, 1'b0, 2'd3, 1'b0, 64'd0);
    do_txn(1, 64'd1023, 1'b1, 2'd1, 1'b0, 64'h0000000000001234);
    do_txn(0, 64'd1022, 1'b1, 2'd1, 1'b0, 64'h000000000000ABCD);
    do_txn(1, 64'd1016, 1'b0, 2'd3, 1'b1, 64'd0);

    // Abort a byte store while its merged word is on the RAM bus.
    set_req(0, 64'h30, 1'b1, 2'd0, 1'b0, {56'd0, ~ref_mem[48]});
    req_valid[0] = 1'b1;
    #1;
    chk("abort_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_wen_write", 64'(mem_wen), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_wen_drop", 64'(mem_wen), 64'd0);
    chk("abort_rsp", 64'(rsp_valid), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_rsp_held", 64'(rsp_valid), 64'd0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_rsp_after", 64'(rsp_valid), 64'd0);
    end
    chk("abort_ram_kept", 64'(ram[48]), 64'(ref_mem[48]));
    $display("txn reset abort during byte store at 30");
    prio_model = 0;

    // Both ports held valid; grants must alternate starting from port 0.
    set_req(0, 64'h10, 1'b0, 2'd3, 1'b0, 64'd0);
    set_req(1, 64'h40, 1'b0, 2'd2, 1'b0, 64'd0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      t = 0;
      while (req_ready == 2'b00 && t < 10) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
      g = req_ready[1] ? 1 : 0;
      chk("grant", 64'(g), 64'(prio_model));
      @(posedge clk);
      #1;
      if (g == 0) finish_txn(0, 64'h10, 1'b0, 2'd3, 1'b0, 64'd0);
      else        finish_txn(1, 64'h40, 1'b0, 2'd2, 1'b0, 64'd0);
      req_valid[g] = 1'b1;
    end
    req_valid = 2'b00;
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      do_txn(int'($urandom_range(0, 1)), 64'($urandom_range(0, 1030)), 1'($urandom),
             2'($urandom), 1'($urandom), {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
